// File: rtl/cplx_pkg.sv
// Shared types and helpers for the complex executor: opcodes, FSM encoding,
// latched instruction layout and {re, im} slice accessors.
package cplx_pkg;
    localparam int CPLX_W = 64;
    localparam int HALF_W = 32;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_CONJ = 3'b011;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_NEG  = 3'b101;
    localparam logic [2:0] OP_SWAP = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPT, S_MUL1, S_MUL2, S_MUL3, S_WRITE
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] src_a;
        logic       cnst_a;
        logic [3:0] src_b;
        logic       cnst_b;
        logic [3:0] dst;
        logic [1:0] wmode;
    } instr_t;

    function automatic logic [HALF_W-1:0] re_of(input logic [CPLX_W-1:0] v);
        return v[CPLX_W-1:HALF_W];
    endfunction

    function automatic logic [HALF_W-1:0] im_of(input logic [CPLX_W-1:0] v);
        return v[HALF_W-1:0];
    endfunction
endpackage

// File: rtl/cplx_mul_seq.sv
// Sequential complex multiply on one shared 32x32 multiplier. Steps 0..3
// produce ar*br, ai*bi, ar*bi, ai*br and fold them into truncated {re, im}.
module cplx_mul_seq
    import cplx_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [1:0]        step_i,
    input  logic [CPLX_W-1:0] a_i,
    input  logic [CPLX_W-1:0] b_i,
    output logic [CPLX_W-1:0] res_o
);
    logic [HALF_W-1:0] x, y, prod;
    logic [HALF_W-1:0] re_q, im_q;

    always_comb begin
        x = re_of(a_i);
        y = re_of(b_i);
        unique case (step_i)
            2'd0: begin x = re_of(a_i); y = re_of(b_i); end
            2'd1: begin x = im_of(a_i); y = im_of(b_i); end
            2'd2: begin x = re_of(a_i); y = im_of(b_i); end
            2'd3: begin x = im_of(a_i); y = re_of(b_i); end
        endcase
    end

    // Low half of the product is identical for signed and unsigned operands.
    assign prod = x * y;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            re_q <= '0;
            im_q <= '0;
        end else if (en_i) begin
            unique case (step_i)
                2'd0: re_q <= prod;
                2'd1: re_q <= re_q - prod;
                2'd2: im_q <= prod;
                2'd3: im_q <= im_q + prod;
            endcase
        end
    end

    assign res_o = {re_q, im_q};
endmodule

// File: rtl/cplx_exec.sv
// Instruction sequencer driving the register bank read/write ports and
// executing one complex op at a time (single-cycle ALU or 4-step MUL).
module cplx_exec
    import cplx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    input  logic              useCnstA,
    input  logic              useCnstB,
    input  logic [3:0]        dst,
    input  logic [1:0]        wmode,
    output logic              busy,
    output logic              done,
    input  logic [CPLX_W-1:0] outA,
    input  logic [CPLX_W-1:0] outB,
    output logic [3:0]        seloutA,
    output logic [3:0]        seloutB,
    output logic              cnstA,
    output logic              cnstB,
    output logic              enrregA,
    output logic              enrregB,
    output logic              regwen,
    output logic [CPLX_W-1:0] inA,
    output logic [3:0]        selwreg,
    output logic [1:0]        endwreg
);
    state_t            state_q, state_d;
    instr_t            instr_q;
    logic [CPLX_W-1:0] opa_q, opb_q, res_q;
    logic [CPLX_W-1:0] mul_a, mul_b, mul_res;
    logic [1:0]        mul_step;
    logic              mul_en;

    function automatic logic [CPLX_W-1:0] alu(input logic [2:0] op,
                                              input logic [CPLX_W-1:0] a,
                                              input logic [CPLX_W-1:0] b);
        logic [HALF_W-1:0] ar, ai, br, bi;
        ar = re_of(a); ai = im_of(a);
        br = re_of(b); bi = im_of(b);
        unique case (op)
            OP_ADD:  return {ar + br, ai + bi};
            OP_SUB:  return {ar - br, ai - bi};
            OP_CONJ: return {ar, -ai};
            OP_NEG:  return {-ar, -ai};
            default: return a;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start)
                instr_q <= '{op: opcode, src_a: srcA, cnst_a: useCnstA,
                             src_b: srcB, cnst_b: useCnstB, dst: dst, wmode: wmode};
            if (state_q == S_CAPT) begin
                opa_q <= outA;
                opb_q <= outB;
                res_q <= alu(instr_q.op, outA, outB);
            end
        end
    end

    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE:  state_d = !start ? S_IDLE : (opcode == OP_NOP) ? S_WRITE : S_READ;
            S_READ:  state_d = S_CAPT;
            S_CAPT:  state_d = (instr_q.op == OP_MUL) ? S_MUL1 : S_WRITE;
            S_MUL1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_MUL3;
            S_MUL3:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // First product is taken while the bank operands are still on outA/outB.
    always_comb begin
        mul_step = 2'd0;
        mul_en   = 1'b0;
        mul_a    = opa_q;
        mul_b    = opb_q;
        unique case (state_q)
            S_CAPT: begin mul_step = 2'd0; mul_a = outA; mul_b = outB; end
            S_MUL1: mul_step = 2'd1;
            S_MUL2: mul_step = 2'd2;
            S_MUL3: mul_step = 2'd3;
            default: ;
        endcase
        if (instr_q.op == OP_MUL && (state_q == S_CAPT || state_q == S_MUL1 ||
                                     state_q == S_MUL2 || state_q == S_MUL3))
            mul_en = 1'b1;
    end

    cplx_mul_seq u_mul (
        .clk_i  (clock),
        .rst_i  (reset),
        .en_i   (mul_en),
        .step_i (mul_step),
        .a_i    (mul_a),
        .b_i    (mul_b),
        .res_o  (mul_res)
    );

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        seloutA = '0;
        seloutB = '0;
        cnstA   = 1'b0;
        cnstB   = 1'b0;
        enrregA = 1'b0;
        enrregB = 1'b0;
        regwen  = 1'b0;
        inA     = '0;
        selwreg = '0;
        endwreg = '0;
        if (state_q == S_READ) begin
            enrregA = 1'b1;
            enrregB = 1'b1;
            seloutA = instr_q.src_a;
            seloutB = instr_q.src_b;
            cnstA   = instr_q.cnst_a;
            cnstB   = instr_q.cnst_b;
        end
        if (state_q == S_WRITE) begin
            done = 1'b1;
            if (instr_q.op != OP_NOP) begin
                regwen  = 1'b1;
                inA     = (instr_q.op == OP_MUL) ? mul_res : res_q;
                selwreg = instr_q.dst;
                endwreg = (instr_q.op == OP_SWAP) ? 2'b11 : instr_q.wmode;
            end
        end
    end
endmodule
